muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Purpose: iterative 32x32 multiply (shift-add) and divide (restoring) unit with HI/LO result registers.
// Latency: 34 cycles from the accepting edge to the hi/lo update; done pulses for one cycle after that edge.
// Backpressure: start is accepted only in IDLE or DONE; start and mthi/mtlo while busy are dropped, never queued.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    // First CALC cycle loads operand magnitudes into the accumulator.
    logic        prime_q, prime_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_div;
    logic        is_signed;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] acc_init;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_trial;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic        may_accept;

    // Operand signs and magnitudes of the latched request.
    always_comb begin
        is_div    = op_q[1];
        is_signed = ~op_q[0];
        neg_a     = is_signed & a_q[31];
        neg_b     = is_signed & b_q[31];
        mag_a     = neg_a ? (32'd0 - a_q) : a_q;
        mag_b     = neg_b ? (32'd0 - b_q) : b_q;
        acc_init  = is_div ? {32'd0, mag_a} : {32'd0, mag_b};
    end

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};
        div_trial = {acc_q[63:32], acc_q[31]};
        div_ge    = (div_trial >= {1'b0, mag_b});
        // When the trial fits, the difference is below the divisor, so 32 bits suffice.
        div_rem   = div_ge ? (div_trial[31:0] - mag_b) : div_trial[31:0];
        div_next  = {div_rem, acc_q[30:0], div_ge};
    end

    // Sign correction of the magnitude results.
    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? (64'd0 - acc_q) : acc_q;
        quo_fix  = (neg_a ^ neg_b) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_fix  = neg_a ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prime_d    = prime_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        may_accept = (state_q == S_IDLE) || (state_q == S_DONE);

        if (may_accept) begin
            if (start_i) begin
                // start wins over a simultaneous move.
                state_d = S_CALC;
                cnt_d   = 5'd0;
                prime_d = 1'b1;
                op_d    = op_i;
                a_d     = opa_i;
                b_d     = opb_i;
            end else begin
                state_d = S_IDLE;
                if (mthi_i) begin
                    hi_d = wdata_i;
                end
                if (mtlo_i) begin
                    lo_d = wdata_i;
                end
            end
        end else if (state_q == S_CALC) begin
            if (prime_q) begin
                acc_d   = acc_init;
                prime_d = 1'b0;
            end else begin
                acc_d = is_div ? div_next : mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
        end else begin
            // FIX: results land in hi/lo on the edge into DONE.
            state_d = S_DONE;
            if (!is_div) begin
                hi_d = prod_fix[63:32];
                lo_d = prod_fix[31:0];
            end else if (b_q == 32'd0) begin
                hi_d = a_q;
                lo_d = 32'hFFFF_FFFF;
            end else begin
                hi_d = rem_fix;
                lo_d = quo_fix;
            end
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            prime_q <= 1'b0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            acc_q   <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prime_q <= prime_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy_o = (state_q == S_CALC) || (state_q == S_FIX);
    assign done_o = (state_q == S_DONE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Purpose: randomized scoreboard bench for muldiv_unit against an arithmetic reference model.
// Latency: expects each result 34 edges after its accepting edge, with a single-cycle done.
// Backpressure: exercises ignored start/move while busy, back-to-back starts in DONE, reset abort.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .op_i    (op),
        .opa_i   (opa),
        .opb_i   (opb),
        .mthi_i  (mthi),
        .mtlo_i  (mtlo),
        .wdata_i (wdata),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always #5 clk = ~clk;

    // Count of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: plain integer arithmetic, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sbv;
        longint      q;
        longint      r;
        logic [63:0] res;
        sa  = $signed(a);
        sbv = $signed(b);
        res = 64'd0;
        case (o)
            2'd0: res = sa * sbv;
            2'd1: res = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    q   = sa / sbv;
                    r   = sa % sbv;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else            res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_done: actual=done at cycle %0d required=no pending result", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("result_hi", {32'd0, hi}, {32'd0, mon_e.hi});
                check("result_lo", {32'd0, lo}, {32'd0, mon_e.lo});
                check("latency", 64'(cyc), 64'(mon_e.due));
                check("busy_in_done", {63'd0, busy}, 64'd0);
            end
        end
    end

    // Called at a negedge: request on the following edge, then scramble inputs.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        exp_t        e;
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        r     = model(o, a, b);
        e.hi  = r[63:32];
        e.lo  = r[31:0];
        e.due = cyc + 35;
        sb.push_back(e);
        m_hi  = r[63:32];
        m_lo  = r[31:0];
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        op    = 2'($urandom);
        opa   = $urandom;
        opb   = $urandom;
        check("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    // Wait until all expectations are consumed; returns at an IDLE negedge.
    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: actual=%0d pending required=0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Wait for the negedge inside the DONE cycle.
    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: actual=done low required=done high");
        end
    endtask

    function automatic logic [31:0] pick_val();
        logic [31:0] v;
        case ($urandom_range(4))
            0:       v = 32'd0;
            1:       v = 32'($urandom_range(15));
            2:       v = $urandom_range(1) ? 32'hFFFF_FFFF : 32'h8000_0000;
            3:       v = 32'd0 - 32'($urandom_range(15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog");
    end

    logic [31:0] w;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        opa   = 32'd0;
        opb   = 32'd0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = 32'd0;
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed corner cases.
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_drain();
        issue(2'd0, 32'hFFFF_FFF9, 32'd3);         wait_drain();
        issue(2'd2, 32'hFFFF_FFF9, 32'd2);         wait_drain();
        issue(2'd3, 32'd100, 32'd0);               wait_drain();
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_drain();
        issue(2'd2, 32'hFFFF_FFF9, 32'd0);         wait_drain();

        // Starts and a move while busy are ignored.
        issue(2'd0, $urandom, $urandom);
        for (int k = 2; k <= 25; k++) begin
            @(negedge clk);
            start = 1'b0;
            mthi  = 1'b0;
            if (k == 5 || k == 10 || k == 20) begin
                start = 1'b1;
                op    = 2'($urandom);
                opa   = $urandom;
                opb   = $urandom;
            end
            if (k == 15) begin
                mthi  = 1'b1;
                wdata = 32'hDEAD_BEEF;
                check("busy_mid_calc", {63'd0, busy}, 64'd1);
            end
        end
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        wait_drain();
        check("hi_after_ignored_move", {32'd0, hi}, {32'd0, m_hi});

        // Reset in the middle of a divide.
        issue(2'd3, $urandom, $urandom | 32'd1);
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        sb.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        issue(2'd1, 32'd3, 32'd5);
        wait_drain();

        // Back-to-back start in DONE, then moves.
        issue(2'd3, $urandom, $urandom_range(100, 1));
        wait_done();
        issue(2'd1, 32'd6, 32'd7);
        wait_drain();
        mtlo  = 1'b1;
        wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        mtlo  = 1'b0;
        check("mtlo_lo", {32'd0, lo}, 64'hA5A5_A5A5);
        check("mtlo_hi_kept", {32'd0, hi}, {32'd0, m_hi});
        m_lo = 32'hA5A5_A5A5;

        w     = $urandom;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = w;
        @(negedge clk);
        mthi  = 1'b0;
        mtlo  = 1'b0;
        check("mtboth", {hi, lo}, {w, w});

        // start beats a simultaneous move.
        mtlo  = 1'b1;
        wdata = 32'h1234_5678;
        issue(2'd0, $urandom, $urandom);
        wait_drain();
        check("start_beats_move", {32'd0, lo}, {32'd0, m_lo});

        // Move in the DONE cycle.
        issue(2'd2, $urandom, $urandom);
        wait_done();
        w     = $urandom;
        mthi  = 1'b1;
        wdata = w;
        @(negedge clk);
        mthi  = 1'b0;
        check("mthi_in_done", {32'd0, hi}, {32'd0, w});

        // Randomized traffic, mixing back-to-back and idle gaps.
        @(negedge clk);
        for (int n = 0; n < 30; n++) begin
            issue(2'($urandom), pick_val(), pick_val());
            if ($urandom_range(1) == 1) wait_done();
            else                        wait_drain();
        end
        wait_drain();
        check("final_hi", {32'd0, hi}, {32'd0, m_hi});
        check("final_lo", {32'd0, lo}, {32'd0, m_lo});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
